// File: rtl/register_32bit_le_aclr_pkg.sv
// Shared constants for the datapath register family: default width and clear value.
package register_32bit_le_aclr_pkg;

  localparam int REG_WIDTH_DEF = 32;
  localparam logic [REG_WIDTH_DEF-1:0] REG_RST_VAL = '0;
  localparam logic REG_RST_BIT = 1'b0;

endpackage

// File: rtl/register_32bit_le_aclr_dff.sv
// Single register bit: D flop with load enable and asynchronous active-low clear.
module dff_le_aclr
  import register_32bit_le_aclr_pkg::*;
(
  input  logic clk,
  input  logic clr_n,
  input  logic le,
  input  logic d,
  output logic q
);

  logic dMux;

  // Recirculate the stored bit when not loading
  assign dMux = le ? d : q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q <= REG_RST_BIT;
    end else begin
      q <= dMux;
    end
  end

endmodule

// File: rtl/register_32bit_le_aclr.sv
// General-purpose parallel-load register: WIDTH enable/clear flops sharing clock and controls.
module register_32bit_le_aclr
  import register_32bit_le_aclr_pkg::*;
#(
  parameter int WIDTH = REG_WIDTH_DEF
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic [WIDTH-1:0] I0,
  input  logic             loadE,
  output logic [WIDTH-1:0] Y
);

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : gBit
      dff_le_aclr uBit (
        .clk   (Clk),
        .clr_n (Clr),
        .le    (loadE),
        .d     (I0[i]),
        .q     (Y[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_register_32bit_le_aclr.sv
// Directed bench for register_32bit_le_aclr with a queue-based scoreboard and monitor.
module tb_register_32bit_le_aclr;

  logic        Clk;
  logic        Clr;
  logic [31:0] I0;
  logic        loadE;
  logic [31:0] Y;

  typedef struct {
    logic [31:0] val;
    string       name;
  } expItem_t;

  expItem_t expQ[$];
  event     sampleEv;
  int       checks = 0;
  int       errs   = 0;

  register_32bit_le_aclr #(.WIDTH(32)) dut (
    .Clk   (Clk),
    .Clr   (Clr),
    .I0    (I0),
    .loadE (loadE),
    .Y     (Y)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  // Monitor: drains every pending expectation against the current register output.
  initial begin
    expItem_t it;
    forever begin
      @(sampleEv);
      while (expQ.size() > 0) begin
        it = expQ.pop_front();
        checks++;
        if (Y !== it.val) begin
          errs++;
          $display("FAIL %s: Y=%h required %h at %0t", it.name, Y, it.val, $time);
        end
      end
    end
  end

  task automatic expectY(input logic [31:0] v, input string nm);
    expItem_t it;
    it.val  = v;
    it.name = nm;
    expQ.push_back(it);
    -> sampleEv;
    #0;
  endtask

  task automatic afterPos();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Clr   = 1'b0;
    loadE = 1'b0;
    I0    = 32'h1111_1111;
    #1;
    expectY(32'h0000_0000, "pwrup_clr_t0");
    afterPos();
    expectY(32'h0000_0000, "pwrup_clr_e1");
    afterPos();
    expectY(32'h0000_0000, "pwrup_clr_e2");

    @(negedge Clk);
    Clr = 1'b1;
    afterPos();
    expectY(32'h0000_0000, "hold_rel_e1");
    afterPos();
    expectY(32'h0000_0000, "hold_rel_e2");

    @(negedge Clk);
    Clr   = 1'b0;
    loadE = 1'b1;
    afterPos();
    expectY(32'h0000_0000, "clr_over_load");

    @(negedge Clk);
    #2;
    Clr = 1'b1;
    #1;
    expectY(32'h0000_0000, "load_before_edge");
    afterPos();
    expectY(32'h1111_1111, "load_1111");

    @(negedge Clk);
    loadE = 1'b0;
    I0    = 32'hDEAD_BEEF;
    for (int k = 0; k < 3; k++) begin
      afterPos();
      expectY(32'h1111_1111, "hold_after_load");
    end

    @(negedge Clk);
    loadE = 1'b1;
    afterPos();
    expectY(32'hDEAD_BEEF, "load_deadbeef");
    I0 = 32'h1234_5678;
    #2;
    expectY(32'hDEAD_BEEF, "i0_between_edges");
    @(negedge Clk);
    loadE = 1'b0;
    afterPos();
    expectY(32'hDEAD_BEEF, "hold_deadbeef");

    Clr = 1'b0;
    #1;
    expectY(32'h0000_0000, "async_clr_mid");
    Clr = 1'b1;
    #1;
    expectY(32'h0000_0000, "async_clr_rel");
    afterPos();
    expectY(32'h0000_0000, "rel_no_load");

    @(negedge Clk);
    loadE = 1'b1;
    I0    = 32'hA5A5_5A5A;
    afterPos();
    expectY(32'hA5A5_5A5A, "load_a5a5");
    @(negedge Clk);
    I0 = 32'hFFFF_FFFF;
    afterPos();
    expectY(32'hFFFF_FFFF, "load_ones");
    @(negedge Clk);
    loadE = 1'b0;
    I0    = 32'h0000_0000;
    afterPos();
    expectY(32'hFFFF_FFFF, "hold_ones");

    #2;
    if (expQ.size() != 0) begin
      checks++;
      errs++;
      $display("FAIL drain: pending=%0d required 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
